mem_bus_router: RTL and testbench

//  Parametrised N-target memory bus router between core and memory-mapped targets (RAM, GPU VRAM, IO).

---
 rtl/mem_bus_pkg.sv | 19 +
 rtl/mem_bus_decode.sv | 28 ++
 rtl/mem_bus_router.sv | 148 ++++++++++++++
 tb/tb_mem_bus_router.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared state encoding, default widths and error codes for the memory bus router
package mem_bus_pkg;

  localparam int DEF_AW        = 12;
  localparam int DEF_DW        = 16;
  localparam int DEF_NUM_PORTS = 3;
  localparam int DEF_PORT_BITS = 2;
  localparam int DEF_TIMEOUT   = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic ERR_NONE = 1'b0;
  localparam logic ERR_SET  = 1'b1;

endpackage

// File: rtl/mem_bus_decode.sv
// rtl/mem_bus_decode.sv - combinational target index, one-hot select and valid decode from a bus address
module mem_bus_decode
  import mem_bus_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int PORT_BITS = DEF_PORT_BITS
) (
  input  logic [AW-1:0]        addr,
  output logic [PORT_BITS-1:0] idx,
  output logic [NUM_PORTS-1:0] onehot,
  output logic                 valid
);

  logic unused_low;

  assign idx        = addr[AW-1 -: PORT_BITS];
  assign valid      = (int'(idx) < NUM_PORTS);
  assign unused_low = ^addr[AW-PORT_BITS-1:0];

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      onehot[i] = (int'(idx) == i);
    end
  end

endmodule

// File: rtl/mem_bus_router.sv
// rtl/mem_bus_router.sv - address-decoded N-target memory bus router with registered handshake
// Optional busy timeout enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_bus_router
  import mem_bus_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int PORT_BITS = DEF_PORT_BITS,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    M_REQ,
  input  logic [AW-1:0]           M_ADDR,
  input  logic [DW-1:0]           M_DATA,
  input  logic                    M_WREN,
  output logic                    M_READY,
  output logic [DW-1:0]           M_Q,
  output logic                    M_ERR,
  output logic [NUM_PORTS-1:0]    S_REQ,
  output logic [NUM_PORTS-1:0]    S_WREN,
  output logic [AW-PORT_BITS-1:0] S_ADDR,
  output logic [DW-1:0]           S_DATA,
  input  logic [NUM_PORTS-1:0]    S_ACK,
  input  logic [NUM_PORTS*DW-1:0] S_Q
);

  state_t                 state_q, state_d;
  logic [PORT_BITS-1:0]   idx_q;
  logic                   wren_q;
  logic [PORT_BITS-1:0]   dec_idx;
  logic [NUM_PORTS-1:0]   dec_onehot;
  logic                   dec_valid;
  logic [DW-1:0]          sel_q;
  logic                   ack_hit;
  logic                   timeout_hit;
  logic                   load;
  logic                   resp_ok;
  logic                   resp_err;

  mem_bus_decode #(
    .AW        (AW),
    .NUM_PORTS (NUM_PORTS),
    .PORT_BITS (PORT_BITS)
  ) u_decode (
    .addr   (M_ADDR),
    .idx    (dec_idx),
    .onehot (dec_onehot),
    .valid  (dec_valid)
  );

  // S_REQ is one-hot on the latched target, so masking avoids indexing S_ACK.
  assign ack_hit = |(S_ACK & S_REQ);
  assign sel_q   = S_Q[int'(idx_q)*DW +: DW];

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  // Compare against TIMEOUT-1 so the transition happens on the TIMEOUT-th busy cycle.
  assign timeout_hit = (state_q == ST_BUSY) && (wait_cnt >= CW'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wait_cnt <= '0;
    end else if (load) begin
      wait_cnt <= '0;
    end else if (state_q == ST_BUSY && wait_cnt != CW'(TIMEOUT)) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    resp_ok  = 1'b0;
    resp_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (M_REQ) begin
          load = 1'b1;
          if (dec_valid) begin
            state_d = ST_BUSY;
          end else begin
            state_d  = ST_RESP;
            resp_err = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (ack_hit) begin
          state_d = ST_RESP;
          resp_ok = 1'b1;
        end else if (timeout_hit) begin
          state_d  = ST_RESP;
          resp_err = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      wren_q  <= 1'b0;
      M_READY <= 1'b0;
      M_Q     <= '0;
      M_ERR   <= ERR_NONE;
      S_REQ   <= '0;
      S_WREN  <= '0;
      S_ADDR  <= '0;
      S_DATA  <= '0;
    end else begin
      state_q <= state_d;
      M_READY <= (state_q == ST_RESP);
      if (load) begin
        idx_q  <= dec_idx;
        wren_q <= M_WREN;
        S_ADDR <= M_ADDR[AW-PORT_BITS-1:0];
        S_DATA <= M_DATA;
        if (dec_valid) begin
          S_REQ  <= dec_onehot;
          S_WREN <= dec_onehot & {NUM_PORTS{M_WREN}};
        end
      end
      if (resp_ok) begin
        M_Q    <= wren_q ? '0 : sel_q;
        M_ERR  <= ERR_NONE;
        S_REQ  <= '0;
        S_WREN <= '0;
      end
      if (resp_err) begin
        M_Q    <= '0;
        M_ERR  <= ERR_SET;
        S_REQ  <= '0;
        S_WREN <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_router.sv
// tb/tb_mem_bus_router.sv - directed scoreboard bench for mem_bus_router
module tb_mem_bus_router;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int NP = 3;
  localparam int PB = 2;
  localparam int TO = 15;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              M_REQ;
  logic [AW-1:0]     M_ADDR;
  logic [DW-1:0]     M_DATA;
  logic              M_WREN;
  logic              M_READY;
  logic [DW-1:0]     M_Q;
  logic              M_ERR;
  logic [NP-1:0]     S_REQ;
  logic [NP-1:0]     S_WREN;
  logic [AW-PB-1:0]  S_ADDR;
  logic [DW-1:0]     S_DATA;
  logic [NP-1:0]     S_ACK;
  logic [NP*DW-1:0]  S_Q;

  typedef struct {
    logic [DW-1:0] q;
    logic          err;
  } resp_t;

  resp_t sb[$];
  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  mem_bus_router #(
    .AW(AW), .DW(DW), .NUM_PORTS(NP), .PORT_BITS(PB), .TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .M_REQ(M_REQ), .M_ADDR(M_ADDR), .M_DATA(M_DATA), .M_WREN(M_WREN),
    .M_READY(M_READY), .M_Q(M_Q), .M_ERR(M_ERR),
    .S_REQ(S_REQ), .S_WREN(S_WREN), .S_ADDR(S_ADDR), .S_DATA(S_DATA),
    .S_ACK(S_ACK), .S_Q(S_Q)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // port < 0 means no target is expected to be selected; ack_wait < 0 means never ack.
  task automatic do_txn(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic wren, input int port, input int ack_wait, input int hold,
                        input logic [DW-1:0] rdata, input logic [NP-1:0] spur,
                        input int exp_lat, input logic [DW-1:0] eq, input logic eerr,
                        input int budget);
    resp_t e, r;
    logic [NP-1:0] ereq;
    bit done;
    e.q   = eq;
    e.err = eerr;
    ereq  = (port >= 0) ? (NP'(1) << port) : '0;
    S_Q   = {NP{16'hDEAD}};
    if (port >= 0) S_Q[port*DW +: DW] = rdata;
    @(posedge CLK); #1;
    M_ADDR = addr; M_DATA = data; M_WREN = wren; M_REQ = 1'b1;
    sb.push_back(e);
    @(posedge CLK); #1;
    done = 1'b0;
    for (int c = 0; c <= budget && !done; c++) begin
      if (M_READY === 1'b1) begin
        r = sb.pop_front();
        check({tag, "_lat"}, 64'(c), 64'(exp_lat));
        check({tag, "_q"},   64'(M_Q), 64'(r.q));
        check({tag, "_err"}, 64'(M_ERR), 64'(r.err));
        M_REQ = 1'b0;
        S_ACK = '0;
        done  = 1'b1;
      end else begin
        if (c < hold) begin
          check({tag, "_sreq"},  64'(S_REQ), 64'(ereq));
          check({tag, "_swren"}, 64'(S_WREN), 64'(wren ? ereq : '0));
          check({tag, "_saddr"}, 64'(S_ADDR), 64'(addr[AW-PB-1:0]));
          check({tag, "_sdata"}, 64'(S_DATA), 64'(data));
        end
        S_ACK = spur;
        if (port >= 0 && ack_wait >= 0 && c >= ack_wait) S_ACK[port] = 1'b1;
        @(posedge CLK); #1;
      end
    end
    if (!done) begin
      check({tag, "_ready_timeout"}, 64'(M_READY), 64'(1));
      void'(sb.pop_front());
      M_REQ = 1'b0;
      S_ACK = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_ready;
    RST_N = 1'b0; M_REQ = 1'b0; M_ADDR = '0; M_DATA = '0; M_WREN = 1'b0;
    S_ACK = '0; S_Q = '0;
    #12;
    check("rst_ready", 64'(M_READY), 64'(0));
    check("rst_err",   64'(M_ERR),   64'(0));
    check("rst_q",     64'(M_Q),     64'(0));
    check("rst_sreq",  64'(S_REQ),   64'(0));
    check("rst_swren", 64'(S_WREN),  64'(0));
    check("rst_saddr", 64'(S_ADDR),  64'(0));
    check("rst_sdata", 64'(S_DATA),  64'(0));
    @(posedge CLK); #1; RST_N = 1'b1;

    do_txn("t1_rd_p0",  12'h012, 16'h0000, 1'b0, 0, 0, 1, 16'hBEEF, 3'b000, 2, 16'hBEEF, 1'b0, 10);
    do_txn("t3_decerr", 12'hC00, 16'h7777, 1'b0, -1, -1, 1, 16'h0000, 3'b000, 1, 16'h0000, 1'b1, 10);
    do_txn("t2_wr_p1",  12'h405, 16'h1234, 1'b1, 1, 3, 4, 16'hFFFF, 3'b000, 5, 16'h0000, 1'b0, 10);
    do_txn("t6_spur",   12'h010, 16'h0000, 1'b0, 0, 2, 3, 16'hA5C3, 3'b100, 4, 16'hA5C3, 1'b0, 10);
    do_txn("t1b_rd_p2", 12'h8FF, 16'h0000, 1'b0, 2, 1, 2, 16'h0F0F, 3'b000, 3, 16'h0F0F, 1'b0, 10);

`ifdef MEM_BUS_TIMEOUT_EN
    do_txn("t4_tmo",    12'h800, 16'h0000, 1'b0, 2, -1, 15, 16'h1111, 3'b000, 16, 16'h0000, 1'b1, 30);
`else
    @(posedge CLK); #1;
    M_ADDR = 12'h800; M_WREN = 1'b0; M_REQ = 1'b1;
    saw_ready = 1'b0;
    for (int c = 0; c < 101; c++) begin
      @(posedge CLK); #1;
      if (M_READY === 1'b1) saw_ready = 1'b1;
    end
    check("t4_no_ready", 64'(saw_ready), 64'(0));
    check("t4_still_busy", 64'(S_REQ), 64'(3'b100));
    #3; RST_N = 1'b0; #1;
    check("t4_rst_sreq", 64'(S_REQ), 64'(0));
    M_REQ = 1'b0;
    @(posedge CLK); #1; RST_N = 1'b1;
`endif

    @(posedge CLK); #1;
    M_ADDR = 12'h400; M_WREN = 1'b0; M_REQ = 1'b1; S_ACK = '0;
    @(posedge CLK); #1;
    check("t5_busy_sreq", 64'(S_REQ), 64'(3'b010));
    @(posedge CLK); #3;
    RST_N = 1'b0; #1;
    check("t5_rst_sreq",  64'(S_REQ),   64'(0));
    check("t5_rst_ready", 64'(M_READY), 64'(0));
    M_REQ = 1'b0;
    @(posedge CLK); #1;
    check("t5_hold_ready", 64'(M_READY), 64'(0));
    RST_N = 1'b1;
    do_txn("t5_after", 12'h4AB, 16'h0000, 1'b0, 1, 1, 2, 16'h5A5A, 3'b000, 3, 16'h5A5A, 1'b0, 10);

    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
